// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers,
// with frame locking until the owner's req_last byte and a start timeout.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 locked,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  input  logic                 tx_notif,
  output logic                 err_timeout
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   win;
  logic            found;
  logic [CW-1:0]   cnt;
  int unsigned     idx;

  // Winner select: owner only while locked, else first valid scanning from rr_ptr.
  always_comb begin
    found     = 1'b0;
    win       = '0;
    idx       = 0;
    req_ready = '0;
    if (state == S_IDLE && !tx_notif) begin
      if (locked) begin
        found = req_valid[owner];
        win   = owner;
      end else begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          idx = 32'(rr_ptr) + k;
          if (idx >= NUM_REQ) idx = idx - NUM_REQ;
          if (!found && req_valid[PW'(idx)]) begin
            found = 1'b1;
            win   = PW'(idx);
          end
        end
      end
    end
    if (found) req_ready = NUM_REQ'(1) << win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tx_send     <= 1'b0;
      tx_data     <= 8'h00;
      grant       <= '0;
      locked      <= 1'b0;
      err_timeout <= 1'b0;
      rr_ptr      <= '0;
      owner       <= '0;
      cnt         <= '0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            tx_data <= req_data[{win, 3'b000} +: 8];
            tx_send <= 1'b1;
            grant   <= req_ready;
            owner   <= win;
            cnt     <= '0;
            state   <= S_SEND;
            if (req_last[win]) begin
              locked <= 1'b0;
              rr_ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
            end else begin
              locked <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (tx_notif) begin
            tx_send <= 1'b0;
            cnt     <= '0;
            state   <= S_WAIT;
          end else if (cnt == CW'(START_TIMEOUT - 1)) begin
            // uart_tx never started: abandon the byte and release any lock
            tx_send     <= 1'b0;
            err_timeout <= 1'b1;
            locked      <= 1'b0;
            cnt         <= '0;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (!tx_notif) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uart_tx model that
// serialises tx_data live, so any instability of tx_data shows on the line.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int BAUD = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last  = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           locked;
  logic           tx_send;
  logic [7:0]     tx_data;
  logic           tx_notif;
  logic           err_timeout;

  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .locked(locked),
    .tx_send(tx_send), .tx_data(tx_data), .tx_notif(tx_notif),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // uart_tx model
  logic       model_en = 1'b1;
  logic       busy = 1'b0;
  int         bcnt = 0;
  int         bidx = 0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_byte = 8'h00;
  int         rx_cnt = 0;
  int         starts = 0;
  logic       line;

  assign tx_notif = busy;

  always_comb begin
    if (!busy || bidx == 9) line = 1'b1;
    else if (bidx == 0)     line = 1'b0;
    else                    line = tx_data[bidx-1];
  end

  always @(posedge clk) begin
    if (!busy) begin
      if (tx_send && model_en) begin
        busy   <= 1'b1;
        bcnt   <= 0;
        bidx   <= 0;
        starts <= starts + 1;
      end
    end else begin
      if (bcnt == BAUD/2 && bidx >= 1 && bidx <= 8) rx_sh <= {line, rx_sh[7:1]};
      if (bcnt == BAUD-1) begin
        bcnt <= 0;
        if (bidx == 9) begin
          busy    <= 1'b0;
          rx_byte <= rx_sh;
          rx_cnt  <= rx_cnt + 1;
        end else begin
          bidx <= bidx + 1;
        end
      end else begin
        bcnt <= bcnt + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  int ready_bad = 0;

  always @(posedge clk) begin
    if (|(req_valid & req_ready)) n_acc++;
    if (!$onehot0(req_ready) || |(req_ready & ~req_valid)) ready_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string tag, output int idx, output logic [7:0] dat);
    bit got;
    got = 0;
    idx = -1;
    dat = 8'h00;
    for (int c = 0; c < 300 && !got; c++) begin
      @(posedge clk);
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) begin
          got = 1;
          idx = i;
          dat = req_data[8*i +: 8];
        end
    end
    #1;
    if (!got) begin
      checks++;
      errors++;
      $error("FAIL %s no accept within 300 cycles", tag);
    end
  endtask

  task automatic wait_rx(input string tag);
    int start;
    start = rx_cnt;
    for (int c = 0; c < 200 && rx_cnt == start; c++) step(1);
    if (rx_cnt == start) begin
      checks++;
      errors++;
      $error("FAIL %s no frame received within 200 cycles", tag);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int         idx;
    logic [7:0] dat;
    int         sends, errs, bad, acc0;

    // Reset state
    step(2);
    chk("rst_tx_send", 32'(tx_send), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err_timeout), 0);
    rst = 1'b0;
    step(1);
    chk("rst_ready_idle", 32'(req_ready), 0);

    // 1. Single byte
    req_data[7:0] = 8'hA5; req_last = 4'b0001; req_valid = 4'b0001;
    wait_accept("t1_acc", idx, dat);
    req_valid = '0;
    chk("t1_idx", 32'(idx), 0);
    chk("t1_tx_data", 32'(tx_data), 32'h A5);
    chk("t1_send_e0", 32'(tx_send), 1);
    chk("t1_grant", 32'(grant), 32'b0001);
    chk("t1_locked", 32'(locked), 0);
    step(1);
    chk("t1_send_notif", 32'({tx_send, tx_notif}), 32'b11);
    step(1);
    chk("t1_send_drop", 32'(tx_send), 0);
    wait_rx("t1_rx");
    chk("t1_rx", 32'(rx_byte), 32'h A5);

    // 2. Round-robin, single-byte frames, from a fresh rr_ptr
    rst = 1'b1; step(2); rst = 1'b0;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10}; req_last = 4'b1111; req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_accept("t2_acc", idx, dat);
      if (k == 4) req_valid = '0;
      chk("t2_idx", 32'(idx), 32'(k % 4));
      chk("t2_tx_data", 32'(tx_data), 32'(8'h10 + k % 4));
      chk("t2_grant", 32'(grant), 32'(1 << (k % 4)));
      wait_rx("t2_rx");
      chk("t2_rx", 32'(rx_byte), 32'(8'h10 + k % 4));
    end

    // 3. Lock: req1 three-byte frame while req0/req2 wait (rr_ptr now 1)
    req_data = {8'h00, 8'h22, 8'hB1, 8'h20}; req_last = 4'b0101; req_valid = 4'b0111;
    wait_accept("t3_acc1", idx, dat);
    chk("t3_idx1", 32'(idx), 1);
    chk("t3_data1", 32'(tx_data), 32'h B1);
    chk("t3_locked1", 32'(locked), 1);
    req_valid = 4'b0101;
    acc0 = n_acc;
    step(80);
    chk("t3_hold_acc", 32'(n_acc), 32'(acc0));
    chk("t3_hold_locked", 32'(locked), 1);
    req_data[15:8] = 8'hB2; req_valid = 4'b0111;
    wait_accept("t3_acc2", idx, dat);
    chk("t3_idx2", 32'(idx), 1);
    chk("t3_data2", 32'(tx_data), 32'h B2);
    req_data[15:8] = 8'hB3; req_last = 4'b0111;
    wait_accept("t3_acc3", idx, dat);
    req_valid = 4'b0101;
    chk("t3_idx3", 32'(idx), 1);
    chk("t3_data3", 32'(tx_data), 32'h B3);
    chk("t3_locked3", 32'(locked), 0);
    wait_accept("t3_acc4", idx, dat);
    req_valid = 4'b0001;
    chk("t3_idx4", 32'(idx), 2);
    chk("t3_data4", 32'(tx_data), 32'h 22);
    wait_accept("t3_acc5", idx, dat);
    req_valid = '0;
    chk("t3_idx5", 32'(idx), 0);
    chk("t3_data5", 32'(tx_data), 32'h 20);
    wait_rx("t3_rx");
    chk("t3_rx", 32'(rx_byte), 32'h 20);

    // 6. Data stability: producer changes req_data right after accept
    req_data[15:8] = 8'hC3; req_last = 4'b0010; req_valid = 4'b0010;
    wait_accept("t6_acc", idx, dat);
    req_data[15:8] = 8'h3C; req_valid = '0;
    chk("t6_idx", 32'(idx), 1);
    step(20);
    chk("t6_tx_data_mid", 32'(tx_data), 32'h C3);
    wait_rx("t6_rx");
    chk("t6_rx", 32'(rx_byte), 32'h C3);

    // 4. Start timeout: uart_tx never responds
    model_en = 1'b0;
    req_data[31:24] = 8'h5A; req_last = 4'b0000; req_valid = 4'b1000;
    wait_accept("t4_acc", idx, dat);
    req_valid = '0;
    chk("t4_idx", 32'(idx), 3);
    chk("t4_locked", 32'(locked), 1);
    sends = 0; errs = 0;
    for (int c = 0; c < 20; c++) begin
      if (tx_send) sends++;
      if (err_timeout) errs++;
      step(1);
    end
    chk("t4_send_cycles", 32'(sends), 16);
    chk("t4_err_pulses", 32'(errs), 1);
    chk("t4_unlocked", 32'(locked), 0);
    chk("t4_send_low", 32'(tx_send), 0);
    model_en = 1'b1;
    req_data[7:0] = 8'h77; req_last = 4'b0001; req_valid = 4'b0001;
    wait_accept("t4_acc2", idx, dat);
    req_valid = '0;
    chk("t4_idx2", 32'(idx), 0);
    wait_rx("t4_rx");
    chk("t4_rx", 32'(rx_byte), 32'h 77);

    // 5. Reset during S_WAIT while uart_tx is mid-frame
    req_data[23:16] = 8'h99; req_last = 4'b0000; req_valid = 4'b0100;
    wait_accept("t5_acc", idx, dat);
    req_valid = '0;
    chk("t5_idx", 32'(idx), 2);
    chk("t5_locked", 32'(locked), 1);
    step(5);
    chk("t5_busy", 32'({tx_notif, tx_send}), 32'b10);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t5_rst_send", 32'(tx_send), 0);
    chk("t5_rst_data", 32'(tx_data), 0);
    chk("t5_rst_grant", 32'(grant), 0);
    chk("t5_rst_locked", 32'(locked), 0);
    req_data[7:0] = 8'h3C; req_last = 4'b0001; req_valid = 4'b0001;
    bad = 0;
    for (int c = 0; c < 100 && tx_notif; c++) begin
      if (req_ready != '0) bad++;
      step(1);
    end
    chk("t5_no_ready_busy", 32'(bad), 0);
    chk("t5_notif_fell", 32'(tx_notif), 0);
    wait_accept("t5_acc2", idx, dat);
    req_valid = '0;
    chk("t5_idx2", 32'(idx), 0);
    chk("t5_data2", 32'(tx_data), 32'h 3C);
    wait_rx("t5_rx");
    chk("t5_rx", 32'(rx_byte), 32'h 3C);

    // Totals: every accept started exactly one uart_tx frame except the timed-out one
    step(10);
    chk("tot_accepts", 32'(n_acc), 16);
    chk("tot_starts", 32'(starts), 15);
    chk("tot_ready_onehot", 32'(ready_bad), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
